// File: rtl/traffic_queue_sensor.sv
// rtl/traffic_queue_sensor.sv - per-street vehicle queue sensor feeding a traffic light controller
//
// Purpose: counts queued vehicles on streets A and B, discharges one vehicle
// every DEPART_CYCLES cycles of GREEN, and reports traffic presence plus sticky
// error flags for lost arrivals, conflicting lights and illegal light codes.
//
// Ports (traffic_queue_sensor):
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   car_a/b    in   one-cycle pulse per arriving vehicle
//   LA/LB      in   [1:0] light colour (GREEN=0, YELLOW=1, RED=2, 3 illegal)
//   TA/TB      out  traffic present (queue non-empty)
//   count_a/b  out  [CNT_W-1:0] queue length
//   ovf_a/b    out  sticky: arrival dropped at full queue
//   conflict   out  sticky: both lights non-RED in the same cycle
//   bad_color  out  sticky: a light carried code 3
//
// Ports (traffic_queue_engine, one per street):
//   clock, reset_n     as above
//   i_car              arrival pulse
//   i_light            [1:0] light colour for this street
//   o_count            [CNT_W-1:0] queue length
//   o_ovf              sticky arrival-lost flag

module traffic_queue_engine #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_car,
  input  logic [1:0]       i_light,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLOW} state_t;

  localparam logic [1:0]       GREEN     = 2'd0;
  localparam logic [7:0]       LAST_TICK = 8'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_timer;
  logic             r_ovf;

  state_t           w_state;
  logic             w_depart;
  logic             w_ovf_set;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_timer_nxt;

  // State is a pure function of the registered count and the live light, so a
  // GREEN seen on an edge already counts as a discharge cycle on that edge.
  always_comb begin
    w_state = ST_IDLE;
    if (r_count != '0) begin
      w_state = (i_light == GREEN) ? ST_FLOW : ST_WAIT;
    end
  end

  always_comb begin
    w_depart    = 1'b0;
    w_ovf_set   = 1'b0;
    w_timer_nxt = '0;
    w_count_nxt = r_count;
    // Timer only runs in FLOW; leaving GREEN mid-interval discards progress.
    if (w_state == ST_FLOW) begin
      if (r_timer == LAST_TICK) begin
        w_depart = 1'b1;
      end else begin
        w_timer_nxt = r_timer + 8'd1;
      end
    end
    // Coincident arrival and departure cancel, even at a full queue.
    if (i_car && !w_depart) begin
      if (r_count == CNT_MAX) begin
        w_ovf_set = 1'b1;
      end else begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end else if (!i_car && w_depart) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_timer <= w_timer_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

module traffic_queue_sensor #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             car_a,
  input  logic             car_b,
  input  logic [1:0]       LA,
  input  logic [1:0]       LB,
  output logic             TA,
  output logic             TB,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             ovf_a,
  output logic             ovf_b,
  output logic             conflict,
  output logic             bad_color
);

  localparam logic [1:0] RED     = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  logic r_conflict;
  logic r_bad_color;
  logic w_conflict_now;
  logic w_bad_now;

  traffic_queue_engine #(
    .CNT_W        (CNT_W),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_engine_a (
    .clock  (clock),
    .reset_n(reset_n),
    .i_car  (car_a),
    .i_light(LA),
    .o_count(count_a),
    .o_ovf  (ovf_a)
  );

  traffic_queue_engine #(
    .CNT_W        (CNT_W),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_engine_b (
    .clock  (clock),
    .reset_n(reset_n),
    .i_car  (car_b),
    .i_light(LB),
    .o_count(count_b),
    .o_ovf  (ovf_b)
  );

  // Code 3 is not RED, so an illegal light also counts toward a conflict.
  assign w_conflict_now = (LA != RED) && (LB != RED);
  assign w_bad_now      = (LA == ILLEGAL) || (LB == ILLEGAL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict  <= 1'b0;
      r_bad_color <= 1'b0;
    end else begin
      r_conflict  <= r_conflict | w_conflict_now;
      r_bad_color <= r_bad_color | w_bad_now;
    end
  end

  assign TA        = (count_a != '0);
  assign TB        = (count_b != '0);
  assign conflict  = r_conflict;
  assign bad_color = r_bad_color;

endmodule
